// File: rtl/alu_share_ctrl.sv
// Two-port arbiter/sequencer for one shared combinational ALU.
// Each op runs IDLE -> EXEC -> RESP; result and zero flag are registered in EXEC.

module alu_share_port (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic win,
  input  logic req_valid,
  input  logic load,
  input  logic owner,
  input  logic resp_phase,
  input  logic resp_ready,
  output logic req_ready,
  output logic resp_valid,
  output logic resp_fire
);
  assign req_ready = idle & win & req_valid;
  assign resp_fire = resp_phase & owner & resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              resp_valid <= 1'b0;
    else if (load && owner)  resp_valid <= 1'b1;
    else if (resp_fire)      resp_valid <= 1'b0;
  end
endmodule

module alu_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int RR_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][3:0]       req_op,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_zero,
  output logic                  resp_err,
  output logic [3:0]            alu_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_zero,
  output logic                  busy
);
  localparam int NPORT = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             cur_g;
  logic             cur_ill;
  logic [NPORT-1:0] win;
  logic [NPORT-1:0] resp_fire;
  logic             gsel;
  logic             hs;
  logic             unused_alu_zero;

  // Zero is recomputed from alu_out so illegal ops can force it.
  assign unused_alu_zero = alu_zero;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == 4'b0010) || (op == 4'b0110) || (op == 4'b0000) || (op == 4'b0001);
  endfunction

  always_comb begin
    win = '0;
    unique case (req_valid)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ((RR_EN != 0) && !last_grant) ? 2'b10 : 2'b01;
      default: win = '0;
    endcase
  end

  assign gsel = win[1];
  assign hs   = |req_ready;

  for (genvar i = 0; i < NPORT; i++) begin : g_port
    alu_share_port u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .idle       (state == IDLE),
      .win        (win[i]),
      .req_valid  (req_valid[i]),
      .load       (state == EXEC),
      .owner      (cur_g == 1'(i)),
      .resp_phase (state == RESP),
      .resp_ready (resp_ready[i]),
      .req_ready  (req_ready[i]),
      .resp_valid (resp_valid[i]),
      .resp_fire  (resp_fire[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_g       <= 1'b0;
      cur_ill     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      alu_op      <= 4'b0010;
      alu_a       <= '0;
      alu_b       <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (hs) begin
          cur_g   <= gsel;
          cur_ill <= !op_legal(req_op[gsel]);
          // Illegal ops leave the ALU inputs untouched.
          if (op_legal(req_op[gsel])) begin
            alu_op <= req_op[gsel];
            alu_a  <= req_a[gsel];
            alu_b  <= req_b[gsel];
          end
          state <= EXEC;
          busy  <= 1'b1;
        end
        EXEC: begin
          resp_result <= cur_ill ? '0 : alu_out;
          resp_zero   <= cur_ill | (alu_out == '0);
          resp_err    <= cur_ill;
          state       <= RESP;
        end
        RESP: if (|resp_fire) begin
          last_grant <= cur_g;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: vector table plus hand sequences, responses scored from a queue.

module tb_alu_share_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0][3:0]   req_op;
  logic [1:0][W-1:0] req_a, req_b;
  logic [W-1:0]      resp_result, alu_a, alu_b, alu_out;
  logic              resp_zero, resp_err, alu_zero, busy;
  logic [3:0]        alu_op;

  logic [1:0]        fp_req_valid, fp_req_ready, fp_resp_valid, fp_resp_ready;
  logic [1:0][3:0]   fp_req_op;
  logic [1:0][W-1:0] fp_req_a, fp_req_b;
  logic [W-1:0]      fp_resp_result, fp_alu_a, fp_alu_b, fp_alu_out;
  logic              fp_resp_zero, fp_resp_err, fp_alu_zero, fp_busy;
  logic [3:0]        fp_alu_op;

  alu_share_ctrl #(.WIDTH(W), .RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_err(resp_err), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy));

  alu_share_ctrl #(.WIDTH(W), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(fp_req_valid), .req_ready(fp_req_ready),
    .req_op(fp_req_op), .req_a(fp_req_a), .req_b(fp_req_b), .resp_valid(fp_resp_valid),
    .resp_ready(fp_resp_ready), .resp_result(fp_resp_result), .resp_zero(fp_resp_zero),
    .resp_err(fp_resp_err), .alu_op(fp_alu_op), .alu_a(fp_alu_a), .alu_b(fp_alu_b),
    .alu_out(fp_alu_out), .alu_zero(fp_alu_zero), .busy(fp_busy));

  // Stand-in ALU; junk on unknown ops and a deliberately wrong zero flag.
  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction
  assign alu_out     = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero    = (alu_out != '0);
  assign fp_alu_out  = alu_f(fp_alu_op, fp_alu_a, fp_alu_b);
  assign fp_alu_zero = (fp_alu_out != '0);

  typedef struct {
    int         port;
    logic [W-1:0] res;
    logic       z;
    logic       e;
  } exp_t;

  typedef struct {
    int         port;
    logic [3:0] op;
    logic [W-1:0] a, b, res;
    logic       z, e;
  } vec_t;

  exp_t sb[$];
  exp_t d_exp[2];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input int p, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    r.port = p;
    r.e = 1'b0;
    case (op)
      4'b0010: r.res = a + b;
      4'b0110: r.res = a - b;
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      default: begin r.res = '0; r.e = 1'b1; end
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on every response handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (resp_valid[p] && resp_ready[p]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty port %0d got %0h want no response", p, resp_result);
          end else begin
            e = sb.pop_front();
            check("resp_port", 64'(p), 64'(e.port));
            check("resp_result", 64'(resp_result), 64'(e.res));
            check("resp_zero", 64'(resp_zero), 64'(e.z));
            check("resp_err", 64'(resp_err), 64'(e.e));
          end
        end
      end
    end
  end

  // Raise valid on ports in en, push expectations in grant order, drop each valid after its handshake.
  task automatic run_reqs(input logic [1:0] en, output int first, output int second);
    logic [1:0] pending, fire;
    int n;
    n = 0; first = -1; second = -1;
    pending = en;
    step();
    req_valid = req_valid | en;
    for (int c = 0; c < 40 && pending != 2'b00; c++) begin
      @(negedge clk);
      fire = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (pending[p] && req_ready[p]) begin
          sb.push_back(d_exp[p]);
          if (n == 0) first = p; else second = p;
          n++;
          fire[p] = 1'b1;
        end
      end
      step();
      req_valid = req_valid & ~fire;
      pending   = pending & ~fire;
    end
    if (pending != 2'b00) begin
      check("req_timeout", 64'(pending), 64'(0));
      req_valid = req_valid & ~pending;
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((sb.size() != 0 || busy) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) check("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  vec_t tbl[8];

  initial begin
    int f, s, g0, g1;
    logic seen;
    logic [1:0] en;

    tbl[0] = '{0, 4'b0010, 32'd5,          32'd7,      32'd12,         1'b0, 1'b0};
    tbl[1] = '{1, 4'b0110, 32'd9,          32'd9,      32'd0,          1'b1, 1'b0};
    tbl[2] = '{0, 4'b0000, 32'h0000_F0F0,  32'h0FF0,   32'h0000_00F0,  1'b0, 1'b0};
    tbl[3] = '{1, 4'b0001, 32'h0000_00F0,  32'h000F,   32'h0000_00FF,  1'b0, 1'b0};
    tbl[4] = '{0, 4'b0110, 32'd0,          32'd1,      32'hFFFF_FFFF,  1'b0, 1'b0};
    tbl[5] = '{1, 4'b0010, 32'hFFFF_FFFF,  32'd1,      32'd0,          1'b1, 1'b0};
    tbl[6] = '{0, 4'b1000, 32'd3,          32'd4,      32'd0,          1'b1, 1'b1};
    tbl[7] = '{0, 4'b0010, 32'h7FFF_FFFF,  32'd1,      32'h8000_0000,  1'b0, 1'b0};

    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 2'b11;
    fp_req_valid = '0; fp_resp_ready = 2'b11;
    fp_req_op[0] = 4'b0010; fp_req_a[0] = 32'd3;  fp_req_b[0] = 32'd4;
    fp_req_op[1] = 4'b0010; fp_req_a[1] = 32'd10; fp_req_b[1] = 32'd20;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_alu_op", 64'(alu_op), 64'(4'b0010));
    check("rst_alu_a", 64'(alu_a), 64'(0));
    check("rst_alu_b", 64'(alu_b), 64'(0));
    check("rst_result", 64'(resp_result), 64'(0));
    check("rst_zero", 64'(resp_zero), 64'(0));
    check("rst_err", 64'(resp_err), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));

    // Latency: ready seen in cycle N, EXEC in N+1, resp_valid in N+2
    req_op[0] = 4'b0010; req_a[0] = 32'd5; req_b[0] = 32'd7;
    d_exp[0] = model(0, 4'b0010, 32'd5, 32'd7);
    run_reqs(2'b01, f, s);
    @(negedge clk);
    check("lat_exec_busy", 64'(busy), 64'(1));
    check("lat_exec_valid", 64'(resp_valid), 64'(0));
    @(negedge clk);
    check("lat_resp_valid", 64'(resp_valid), 64'(2'b01));
    drain();

    // Vector table, one port at a time
    for (int i = 0; i < 8; i++) begin
      int p;
      p = tbl[i].port;
      req_op[p] = tbl[i].op; req_a[p] = tbl[i].a; req_b[p] = tbl[i].b;
      d_exp[p] = '{p, tbl[i].res, tbl[i].z, tbl[i].e};
      en = 2'b00;
      en[p] = 1'b1;
      run_reqs(en, f, s);
      check("tbl_grant", 64'(f), 64'(p));
      drain();
    end

    // Illegal op leaves ALU drive from previous op (add 7fffffff+1)
    req_op[1] = 4'b0111; req_a[1] = 32'hAAAA; req_b[1] = 32'hBBBB;
    d_exp[1] = model(1, 4'b0111, 32'hAAAA, 32'hBBBB);
    run_reqs(2'b10, f, s);
    @(negedge clk);
    check("ill_alu_op", 64'(alu_op), 64'(4'b0010));
    check("ill_alu_a", 64'(alu_a), 64'(32'h7FFF_FFFF));
    check("ill_alu_b", 64'(alu_b), 64'(1));
    drain();

    // Round robin ties; last grant was port 1 so port 0 wins
    req_op[0] = 4'b0110; req_a[0] = 32'd9;    req_b[0] = 32'd9;
    req_op[1] = 4'b0001; req_a[1] = 32'hF0;   req_b[1] = 32'h0F;
    d_exp[0] = model(0, 4'b0110, 32'd9, 32'd9);
    d_exp[1] = model(1, 4'b0001, 32'hF0, 32'h0F);
    run_reqs(2'b11, f, s);
    check("rr_first", 64'(f), 64'(0));
    check("rr_second", 64'(s), 64'(1));
    drain();
    run_reqs(2'b11, f, s);
    check("rr_again_first", 64'(f), 64'(0));
    drain();
    d_exp[0] = model(0, 4'b0110, 32'd9, 32'd9);
    run_reqs(2'b01, f, s);
    drain();
    run_reqs(2'b11, f, s);
    check("rr_after_p0_first", 64'(f), 64'(1));
    check("rr_after_p0_second", 64'(s), 64'(0));
    drain();

    // Fixed priority instance: port 0 always wins
    g0 = 0; g1 = 0; seen = 1'b0;
    step();
    fp_req_valid = 2'b11;
    for (int c = 0; c < 40 && g0 < 4; c++) begin
      @(negedge clk);
      if (fp_req_ready[0]) g0++;
      if (fp_req_ready[1]) g1++;
      if (fp_resp_valid[0] && !seen) begin
        check("fp_result", 64'(fp_resp_result), 64'(7));
        seen = 1'b1;
      end
    end
    step();
    fp_req_valid = 2'b00;
    check("fp_grants_p0", 64'(g0), 64'(4));
    check("fp_grants_p1", 64'(g1), 64'(0));
    check("fp_result_seen", 64'(seen), 64'(1));

    // Backpressure: 0-1 held for 5 cycles; port 1 ready/requests ignored meanwhile
    step();
    resp_ready = 2'b10;
    req_op[0] = 4'b0110; req_a[0] = 32'd0; req_b[0] = 32'd1;
    d_exp[0] = model(0, 4'b0110, 32'd0, 32'd1);
    run_reqs(2'b01, f, s);
    for (int c = 0; c < 5 && !resp_valid[0]; c++) @(negedge clk);
    req_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 64'(resp_valid), 64'(2'b01));
      check("bp_result", 64'(resp_result), 64'(32'hFFFF_FFFF));
      check("bp_busy", 64'(busy), 64'(1));
      check("bp_req_ready", 64'(req_ready), 64'(0));
    end
    step();
    req_valid = 2'b00;
    resp_ready = 2'b11;
    drain();

    // Reset during RESP
    step();
    resp_ready = 2'b01;
    req_op[1] = 4'b0010; req_a[1] = 32'd1; req_b[1] = 32'd1;
    d_exp[1] = model(1, 4'b0010, 32'd1, 32'd1);
    run_reqs(2'b10, f, s);
    for (int c = 0; c < 5 && !resp_valid[1]; c++) @(negedge clk);
    check("pre_rst_valid", 64'(resp_valid), 64'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(resp_valid), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    sb.delete();
    @(negedge clk);
    resp_ready = 2'b11;
    req_op[0] = 4'b0010; req_a[0] = 32'd3; req_b[0] = 32'd4;
    req_valid = 2'b01;
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'(2'b01));
    sb.push_back(model(0, 4'b0010, 32'd3, 32'd4));
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'(1));
    drain();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
